// File: rtl/ibex_shadow_stack_mc.sv
`default_nettype none
// ============================================================================
// Module   : ibex_shadow_stack_mc
// Brief    : Multi-context return-address shadow stack with sticky error capture.
// Revision : 1.0
// ============================================================================
module ibex_shadow_stack_mc #(
    parameter  int unsigned DATA_WIDTH    = 32,
    parameter  int unsigned DEPTH         = 16,
    parameter  int unsigned NUM_CTX       = 2,
    parameter  int unsigned OVERFLOW_MODE = 0,
    parameter  int unsigned IGNORE_LSB    = 1,
    localparam int unsigned CTX_W         = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    localparam int unsigned PTR_W         = $clog2(DEPTH),
    localparam int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CTX_W-1:0]      ctx_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_addr_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] pop_addr_i,
    input  logic                  err_clr_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  unchecked_o,
    output logic                  err_pulse_o,
    output logic                  error_o,
    output logic [1:0]            err_code_o,
    output logic [CTX_W-1:0]      err_ctx_o
);

    localparam logic [DATA_WIDTH-1:0] CMP_MASK =
        (IGNORE_LSB != 0) ? {{(DATA_WIDTH-1){1'b1}}, 1'b0} : {DATA_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_MISMATCH  = 2'd3
    } err_code_e;

    logic [DATA_WIDTH-1:0] mem_q     [NUM_CTX][DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q  [NUM_CTX];
    logic [PTR_W-1:0]      wr_ptr_d  [NUM_CTX];
    logic [CNT_W-1:0]      count_q   [NUM_CTX];
    logic [CNT_W-1:0]      count_d   [NUM_CTX];
    logic [NUM_CTX-1:0]    wrapped_q;
    logic [NUM_CTX-1:0]    wrapped_d;

    logic                  ctx_valid;
    logic [PTR_W-1:0]      cur_ptr;
    logic [PTR_W-1:0]      top_ptr;
    logic [CNT_W-1:0]      cur_cnt;
    logic                  cur_wrapped;
    logic [DATA_WIDTH-1:0] top_data;
    logic                  cur_empty;
    logic                  cur_full;
    logic                  cmp_miss;

    logic                  mem_we;
    logic [PTR_W-1:0]      mem_waddr;
    err_code_e             ev_code;
    logic                  unchecked_d;

    logic                  unchecked_q;
    logic                  err_pulse_q;
    logic                  error_q;
    err_code_e             err_code_q;
    logic [CTX_W-1:0]      err_ctx_q;

    assign ctx_valid = (32'(ctx_i) < NUM_CTX);

    // Selected-context view; an out-of-range context reads as an empty stack.
    always_comb begin
        cur_ptr     = '0;
        cur_cnt     = '0;
        cur_wrapped = 1'b0;
        top_ptr     = '0;
        top_data    = '0;
        if (ctx_valid) begin
            cur_ptr     = wr_ptr_q[ctx_i];
            cur_cnt     = count_q[ctx_i];
            cur_wrapped = wrapped_q[ctx_i];
            top_ptr     = cur_ptr - PTR_W'(1);
            top_data    = mem_q[ctx_i][top_ptr];
        end
    end

    assign cur_empty = (cur_cnt == '0);
    assign cur_full  = (cur_cnt == FULL_CNT);
    assign cmp_miss  = (((top_data ^ pop_addr_i) & CMP_MASK) != '0);
    assign count_o   = cur_cnt;

    // Pop is resolved first against the pre-push top; a push paired with a
    // successful pop reuses the freed slot so pointer and count stay put.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        mem_we      = 1'b0;
        mem_waddr   = cur_ptr;
        ev_code     = ERR_NONE;
        unchecked_d = 1'b0;
        if (ctx_valid) begin
            if (pop_i) begin
                if (!cur_empty) begin
                    if (cmp_miss) begin
                        ev_code = ERR_MISMATCH;
                    end
                    if (push_i) begin
                        mem_we    = 1'b1;
                        mem_waddr = top_ptr;
                    end else begin
                        wr_ptr_d[ctx_i] = top_ptr;
                        count_d[ctx_i]  = cur_cnt - CNT_W'(1);
                    end
                end else if (cur_wrapped) begin
                    unchecked_d      = 1'b1;
                    wrapped_d[ctx_i] = 1'b0;
                end else begin
                    ev_code = ERR_UNDERFLOW;
                end
            end
            if (push_i && !(pop_i && !cur_empty)) begin
                if (!cur_full) begin
                    mem_we          = 1'b1;
                    mem_waddr       = cur_ptr;
                    wr_ptr_d[ctx_i] = cur_ptr + PTR_W'(1);
                    count_d[ctx_i]  = cur_cnt + CNT_W'(1);
                end else if (OVERFLOW_MODE == 0) begin
                    ev_code = ERR_OVERFLOW;
                end else begin
                    mem_we           = 1'b1;
                    mem_waddr        = cur_ptr;
                    wr_ptr_d[ctx_i]  = cur_ptr + PTR_W'(1);
                    wrapped_d[ctx_i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            wrapped_q   <= '0;
            unchecked_q <= 1'b0;
            err_pulse_q <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_ctx_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            unchecked_q <= unchecked_d;
            err_pulse_q <= (ev_code != ERR_NONE);
            // First error wins, but a clear in the same cycle lets a new one in.
            if ((ev_code != ERR_NONE) && (!error_q || err_clr_i)) begin
                error_q    <= 1'b1;
                err_code_q <= ev_code;
                err_ctx_q  <= ctx_i;
            end else if (err_clr_i) begin
                error_q    <= 1'b0;
                err_code_q <= ERR_NONE;
                err_ctx_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[ctx_i][mem_waddr] <= push_addr_i;
        end
    end

    assign unchecked_o = unchecked_q;
    assign err_pulse_o = err_pulse_q;
    assign error_o     = error_q;
    assign err_code_o  = err_code_q;
    assign err_ctx_o   = err_ctx_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_shadow_stack_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_shadow_stack_mc
// Brief    : Scoreboard bench: one error-mode and one wrap-mode shadow stack.
// Revision : 1.0
// ============================================================================
module tb_ibex_shadow_stack_mc;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0] cnt;
        logic       unc;
        logic       pls;
        logic       err;
        logic [1:0] code;
        logic       cx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctx = 1'b0;
    logic [1:0]  push = '0;
    logic [1:0]  pop = '0;
    logic [1:0]  clr = '0;
    logic [31:0] paddr = '0;
    logic [31:0] raddr = '0;

    logic [1:0][2:0] cnt;
    logic [1:0]      unc;
    logic [1:0]      pls;
    logic [1:0]      err;
    logic [1:0][1:0] code;
    logic [1:0]      ectx;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: oldest entry at index 0, per DUT (m) and context.
    logic [31:0] mstk [2][2][DEPTH];
    int          msz  [2][2];
    bit          mwr  [2][2];
    bit          merr [2];
    logic [1:0]  mcode[2];
    logic        mcx  [2];

    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    ibex_shadow_stack_mc #(
        .DATA_WIDTH(32), .DEPTH(DEPTH), .NUM_CTX(2), .OVERFLOW_MODE(0), .IGNORE_LSB(1)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .ctx_i(ctx),
        .push_i(push[0]), .push_addr_i(paddr), .pop_i(pop[0]), .pop_addr_i(raddr),
        .err_clr_i(clr[0]), .count_o(cnt[0]), .unchecked_o(unc[0]),
        .err_pulse_o(pls[0]), .error_o(err[0]), .err_code_o(code[0]), .err_ctx_o(ectx[0])
    );

    ibex_shadow_stack_mc #(
        .DATA_WIDTH(32), .DEPTH(DEPTH), .NUM_CTX(2), .OVERFLOW_MODE(1), .IGNORE_LSB(1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .ctx_i(ctx),
        .push_i(push[1]), .push_addr_i(paddr), .pop_i(pop[1]), .pop_addr_i(raddr),
        .err_clr_i(clr[1]), .count_o(cnt[1]), .unchecked_o(unc[1]),
        .err_pulse_o(pls[1]), .error_o(err[1]), .err_code_o(code[1]), .err_ctx_o(ectx[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                msz[m][c] = 0;
                mwr[m][c] = 1'b0;
            end
            merr[m]  = 1'b0;
            mcode[m] = 2'd0;
            mcx[m]   = 1'b0;
        end
    endfunction

    function automatic exp_t model_step(input int m, input logic c, input logic pu,
                                        input logic [31:0] pa, input logic po,
                                        input logic [31:0] ra, input logic cl);
        exp_t e;
        int   ev = 0;
        logic u  = 1'b0;
        int   ci = int'(c);
        if (po) begin
            if (msz[m][ci] > 0) begin
                if (((mstk[m][ci][msz[m][ci]-1] ^ ra) & 32'hFFFF_FFFE) != 0) ev = 3;
                msz[m][ci]--;
            end else if (mwr[m][ci]) begin
                u = 1'b1;
                mwr[m][ci] = 1'b0;
            end else begin
                ev = 2;
            end
        end
        if (pu) begin
            if (msz[m][ci] < DEPTH) begin
                mstk[m][ci][msz[m][ci]] = pa;
                msz[m][ci]++;
            end else if (m == 0) begin
                ev = 1;
            end else begin
                for (int i = 0; i < DEPTH-1; i++) mstk[m][ci][i] = mstk[m][ci][i+1];
                mstk[m][ci][DEPTH-1] = pa;
                mwr[m][ci] = 1'b1;
            end
        end
        if (ev != 0 && (!merr[m] || cl)) begin
            merr[m]  = 1'b1;
            mcode[m] = ev[1:0];
            mcx[m]   = c;
        end else if (cl) begin
            merr[m]  = 1'b0;
            mcode[m] = 2'd0;
            mcx[m]   = 1'b0;
        end
        e.cnt  = 3'(msz[m][ci]);
        e.unc  = u;
        e.pls  = (ev != 0);
        e.err  = merr[m];
        e.code = mcode[m];
        e.cx   = mcx[m];
        return e;
    endfunction

    task automatic compare_dut(input int m, input exp_t e);
        chk($sformatf("d%0d count", m),     32'(cnt[m]),  32'(e.cnt));
        chk($sformatf("d%0d unchecked", m), 32'(unc[m]),  32'(e.unc));
        chk($sformatf("d%0d err_pulse", m), 32'(pls[m]),  32'(e.pls));
        chk($sformatf("d%0d error", m),     32'(err[m]),  32'(e.err));
        chk($sformatf("d%0d err_code", m),  32'(code[m]), 32'(e.code));
        chk($sformatf("d%0d err_ctx", m),   32'(ectx[m]), 32'(e.cx));
    endtask

    // sel bit m routes the request to DUT m; the other DUT sees an idle cycle.
    task automatic op(input int sel, input logic c, input logic pu, input logic [31:0] pa,
                      input logic po, input logic [31:0] ra, input logic cl);
        exp_t e;
        @(negedge clk);
        ctx   = c;
        paddr = pa;
        raddr = ra;
        for (int m = 0; m < 2; m++) begin
            push[m] = pu && sel[m];
            pop[m]  = po && sel[m];
            clr[m]  = cl && sel[m];
        end
        sb0.push_back(model_step(0, c, push[0], pa, pop[0], ra, clr[0]));
        sb1.push_back(model_step(1, c, push[1], pa, pop[1], ra, clr[1]));
        @(posedge clk);
        #1;
        if (sb0.size() == 0) chk("sb0 empty", 32'd1, 32'd0);
        else begin e = sb0.pop_front(); compare_dut(0, e); end
        if (sb1.size() == 0) chk("sb1 empty", 32'd1, 32'd0);
        else begin e = sb1.pop_front(); compare_dut(1, e); end
        push = '0;
        pop  = '0;
        clr  = '0;
    endtask

    task automatic psh(input int sel, input logic c, input logic [31:0] a);
        op(sel, c, 1'b1, a, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic pp(input int sel, input logic c, input logic [31:0] a);
        op(sel, c, 1'b0, 32'h0, 1'b1, a, 1'b0);
    endtask

    task automatic clear_err(input int sel);
        op(sel, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s d%0d count", tag, m), 32'(cnt[m]),  32'd0);
            chk($sformatf("%s d%0d error", tag, m), 32'(err[m]),  32'd0);
            chk($sformatf("%s d%0d code", tag, m),  32'(code[m]), 32'd0);
            chk($sformatf("%s d%0d pulse", tag, m), 32'(pls[m]),  32'd0);
            chk($sformatf("%s d%0d unchk", tag, m), 32'(unc[m]),  32'd0);
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic LIFO on ctx 0, both DUTs
        psh(3, 1'b0, 32'h100);
        psh(3, 1'b0, 32'h204);
        psh(3, 1'b0, 32'h308);
        pp(3, 1'b0, 32'h308);
        pp(3, 1'b0, 32'h204);
        pp(3, 1'b0, 32'h100);

        // Error-mode overflow on ctx 1, then LIFO drain of the retained four
        for (int i = 1; i <= 5; i++) psh(1, 1'b1, 32'hA00 + 32'(4*i));
        for (int i = 4; i >= 1; i--) pp(1, 1'b1, 32'hA00 + 32'(4*i));
        clear_err(1);

        // Wrap-mode: six pushes into four slots, then six pops
        for (int i = 0; i < 6; i++) psh(2, 1'b0, 32'h2000 + 32'(16*i));
        for (int i = 5; i >= 0; i--) pp(2, 1'b0, 32'h2000 + 32'(16*i));
        clear_err(3);

        // LSB-insensitive compare, then a real mismatch
        psh(3, 1'b0, 32'h1000);
        pp(3, 1'b0, 32'h1001);
        psh(3, 1'b0, 32'h1000);
        pp(3, 1'b0, 32'h1004);
        clear_err(3);

        // Same-cycle pop+push on a non-empty context
        psh(3, 1'b0, 32'h40);
        op(3, 1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0);
        pp(3, 1'b0, 32'h80);
        // Same-cycle pop+push on an empty context: underflow, push still lands
        op(3, 1'b1, 1'b1, 32'hC0, 1'b1, 32'h0, 1'b0);
        pp(3, 1'b1, 32'hC0);
        clear_err(3);

        // First-error-wins, then clear colliding with a new mismatch
        pp(3, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) psh(1, 1'b1, 32'h3000 + 32'(4*i));
        psh(3, 1'b0, 32'h500);
        op(3, 1'b0, 1'b0, 32'h0, 1'b1, 32'h504, 1'b1);
        clear_err(3);

        // Reset while a push is in flight
        psh(3, 1'b1, 32'h600);
        @(negedge clk);
        ctx     = 1'b1;
        push    = 2'b11;
        paddr   = 32'h700;
        rst     = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        push = '0;
        rst  = 1'b0;
        psh(3, 1'b1, 32'h800);
        pp(3, 1'b1, 32'h800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
